// File: rtl/relogio_contador_ajuste.sv
// 24 h timekeeping core: 1 Hz prescaler, hh:mm:ss counters, three-button set.
// Define AJUSTE_AUTOREPEAT_EN to add hold-to-repeat on inc/dec in adjust modes.
module relogio_contador_ajuste #(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_modo,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic [1:0] modo_ajuste,
    output logic       tick_1hz
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_chk
        $error("relogio_contador_ajuste: parameter out of range");
    end

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        AJ_HORAS = 2'd1,
        AJ_MIN   = 2'd2,
        AJ_SEG   = 2'd3
    } modo_t;

    // Button bit order everywhere: [0]=modo, [1]=inc, [2]=dec
    logic [2:0]    w_btn;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db;
    logic [2:0]    r_db_d;
    logic [DW-1:0] r_dbcnt [3];
    logic [2:0]    w_press;

    modo_t         r_state;
    modo_t         w_state_next;
    logic          w_adjust;
    logic          w_ev_modo;
    logic          w_ev_inc;
    logic          w_ev_dec;

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_tick;
    logic [5:0]    r_seg;
    logic [5:0]    r_min;
    logic [5:0]    r_hor;

    assign w_btn = {btn_dec, btn_inc, btn_modo};

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 3; i++) r_dbcnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]    <= r_sync2[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_press   = r_db & ~r_db_d;
    assign w_ev_modo = w_press[0];
    assign w_adjust  = (r_state != NORMAL);

    always_ff @(posedge clk_100MHz) begin
        if (reset) r_state <= NORMAL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ev_modo) begin
            unique case (r_state)
                NORMAL:   w_state_next = AJ_HORAS;
                AJ_HORAS: w_state_next = AJ_MIN;
                AJ_MIN:   w_state_next = AJ_SEG;
                AJ_SEG:   w_state_next = NORMAL;
            endcase
        end
    end

`ifdef AJUSTE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    // Index 0 repeats inc, index 1 repeats dec
    logic [RW-1:0] r_rep_cnt [2];
    logic [1:0]    r_rep_ph;
    logic [1:0]    w_rep_hold;
    logic [1:0]    w_rep_ev;

    always_comb begin
        w_rep_hold = '0;
        w_rep_ev   = '0;
        for (int i = 0; i < 2; i++) begin
            w_rep_hold[i] = w_adjust && r_db[i+1] &&
                            !(&r_db[2:1]) && !w_ev_modo;
            w_rep_ev[i]   = w_rep_hold[i] &&
                            (r_rep_cnt[i] == (r_rep_ph[i] ?
                             RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_rep_ph <= '0;
            for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_rep_hold[i]) begin
                    r_rep_cnt[i] <= '0;
                    r_rep_ph[i]  <= 1'b0;
                end else if (w_rep_ev[i]) begin
                    r_rep_cnt[i] <= RW'(1);
                    r_rep_ph[i]  <= 1'b1;
                end else begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
                end
            end
        end
    end

    assign w_ev_inc = w_press[1] | w_rep_ev[0];
    assign w_ev_dec = w_press[2] | w_rep_ev[1];
`else
    assign w_ev_inc = w_press[1];
    assign w_ev_dec = w_press[2];
`endif

    function automatic logic [5:0] f_step(input logic [5:0] v,
                                          input logic [5:0] lim,
                                          input logic       up);
        if (up) return (v == lim) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? lim : v - 6'd1;
    endfunction

    // Prescaler only runs while staying in NORMAL, so re-entry starts at 0
    always_comb begin
        w_presc_next = '0;
        if (r_state == NORMAL && w_state_next == NORMAL &&
            r_presc != PW'(TICK_DIV - 1))
            w_presc_next = r_presc + PW'(1);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_seg   <= '0;
            r_min   <= '0;
            r_hor   <= '0;
        end else begin
            r_presc <= w_presc_next;
            r_tick  <= (w_state_next == NORMAL) &&
                       (w_presc_next == PW'(TICK_DIV - 1));
            if (r_tick) begin
                r_seg <= f_step(r_seg, 6'd59, 1'b1);
                if (r_seg == 6'd59) begin
                    r_min <= f_step(r_min, 6'd59, 1'b1);
                    if (r_min == 6'd59)
                        r_hor <= f_step(r_hor, 6'd23, 1'b1);
                end
            end else if (w_adjust && !w_ev_modo && (w_ev_inc ^ w_ev_dec)) begin
                unique case (1'b1)
                    r_state == AJ_HORAS: r_hor <= f_step(r_hor, 6'd23, w_ev_inc);
                    r_state == AJ_MIN:   r_min <= f_step(r_min, 6'd59, w_ev_inc);
                    default:             r_seg <= f_step(r_seg, 6'd59, w_ev_inc);
                endcase
            end
        end
    end

    assign segundos    = r_seg;
    assign minutos     = r_min;
    assign horas       = r_hor;
    assign modo_ajuste = r_state;
    assign tick_1hz    = r_tick;

endmodule

// File: tb/tb_relogio_contador_ajuste.sv
// Scoreboard bench for relogio_contador_ajuste: stimulus pushes expected
// snapshots, a monitor pops them on every visible output change.
`timescale 1ns/1ps
module tb_relogio_contador_ajuste;
    localparam int TD = 10;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int DAY = 86400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_modo = 1'b0;
    logic       b_inc = 1'b0;
    logic       b_dec = 1'b0;
    logic [5:0] seg_o;
    logic [5:0] min_o;
    logic [5:0] hor_o;
    logic [1:0] modo_o;
    logic       tick_o;

    relogio_contador_ajuste #(
        .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_100MHz(clk), .reset(rst),
        .btn_modo(b_modo), .btn_inc(b_inc), .btn_dec(b_dec),
        .segundos(seg_o), .minutos(min_o), .horas(hor_o),
        .modo_ajuste(modo_o), .tick_1hz(tick_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int t;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   n_tick = 0;
    int   mon_t = 0;
    int   m_t = 0;
    int   m_mode = 0;

    function automatic int dut_t();
        return int'(hor_o) * 3600 + int'(min_o) * 60 + int'(seg_o);
    endfunction

    function automatic int field_of(input int t, input int md);
        case (md)
            1:       return t / 3600;
            2:       return (t / 60) % 60;
            default: return t % 60;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Monitor: model time advances on each observed tick; mode changes and
    // adjust-mode edits must match the next queued expectation.
    initial begin : monitor
        int   p_t;
        int   p_mode;
        int   c_t;
        int   c_mode;
        int   e_t;
        bit   p_tick;
        exp_t e;
        p_t = 0;
        p_mode = 0;
        p_tick = 1'b0;
        forever begin
            @(negedge clk);
            c_t = dut_t();
            c_mode = int'(modo_o);
            if (rst) begin
                mon_t = 0;
                p_tick = 1'b0;
            end else begin
                if (p_tick) mon_t = (mon_t + 1) % DAY;
                if (c_mode != p_mode || (c_mode != 0 && c_t != p_t)) begin
                    if (q.size() == 0) begin
                        check("unexpected_change", c_t * 4 + c_mode, p_t * 4 + p_mode);
                    end else begin
                        e = q.pop_front();
                        e_t = (e.t < 0) ? mon_t : e.t;
                        check("sb_mode", c_mode, e.mode);
                        check("sb_time", c_t, e_t);
                        mon_t = e_t;
                    end
                end else if (c_t != p_t || p_tick) begin
                    check("tick_time", c_t, mon_t);
                end
                if (tick_o) begin
                    n_tick++;
                    check("tick_in_normal", c_mode, 0);
                end
                p_tick = tick_o;
            end
            p_t = c_t;
            p_mode = c_mode;
        end
    end

    task automatic sync();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            cyc(1);
            k++;
        end
        check("drain", q.size(), 0);
        q.delete();
        m_t = mon_t;
    endtask

    task automatic chk_now(input string name);
        check({name, "_mode"}, int'(modo_o), m_mode);
        check({name, "_time"}, dut_t(), mon_t);
    endtask

    task automatic press(input bit pm, input bit pi, input bit pd);
        exp_t e;
        int   h;
        int   mi;
        int   s;
        int   d;
        if (pm) begin
            m_mode = (m_mode + 1) % 4;
            e.mode = m_mode;
            e.t = (m_mode == 1) ? -1 : m_t;
            q.push_back(e);
        end else if (m_mode != 0 && (pi ^ pd)) begin
            h = m_t / 3600;
            mi = (m_t / 60) % 60;
            s = m_t % 60;
            d = pi ? 1 : -1;
            case (m_mode)
                1:       h = (h + d + 24) % 24;
                2:       mi = (mi + d + 60) % 60;
                default: s = (s + d + 60) % 60;
            endcase
            m_t = h * 3600 + mi * 60 + s;
            e.mode = m_mode;
            e.t = m_t;
            q.push_back(e);
        end
        b_modo = pm;
        b_inc = pi;
        b_dec = pd;
        cyc(8);
        b_modo = 1'b0;
        b_inc = 1'b0;
        b_dec = 1'b0;
        cyc(8 + int'($urandom_range(0, 3)));
        sync();
    endtask

    task automatic set_field(input int tgt);
        int lim;
        int v;
        bit up;
        lim = (m_mode == 1) ? 24 : 60;
        repeat (int'($urandom_range(0, 2))) begin
            up = 1'($urandom_range(0, 1));
            press(1'b0, up, !up);
        end
        v = field_of(m_t, m_mode);
        while (v != tgt) begin
            up = ((tgt - v + lim) % lim) <= lim / 2;
            press(1'b0, up, !up);
            v = field_of(m_t, m_mode);
        end
    endtask

    initial begin : stim
        exp_t     e;
        int       h0;
        int       k;
        int       n_rep;
        bit [2:0] r;

        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        n_tick = 0;
        check("reset_time", dut_t(), 0);
        check("reset_mode", int'(modo_o), 0);
        check("reset_tick", int'(tick_o), 0);

        // Free run from reset
        cyc(600);
        cyc(2);
        check("run_ticks", n_tick, 600 / TD);
        check("run_time", dut_t(), (600 / TD) % DAY);
        m_t = mon_t;
        chk_now("run");

        // Preset 23:59:59 and roll over midnight
        press(1'b1, 1'b0, 1'b0);
        set_field(23);
        press(1'b1, 1'b0, 1'b0);
        set_field(59);
        press(1'b1, 1'b0, 1'b0);
        set_field(59);
        check("preset", m_t, 86399);
        press(1'b1, 1'b0, 1'b0);
        cyc(3);
        check("midnight_time", dut_t(), (86399 + 1) % DAY);
        check("midnight_mode", int'(modo_o), 0);

        // Bouncing modo: only the final stable hold may advance
        m_mode = 1;
        e.mode = 1;
        e.t = -1;
        q.push_back(e);
        for (int i = 0; i < 20; i++) begin
            b_modo = (i % 2 == 0);
            cyc(2);
        end
        b_modo = 1'b1;
        cyc(10);
        b_modo = 1'b0;
        cyc(10);
        sync();
        chk_now("debounce");

        // Per-field wrap without carry
        set_field(5);
        press(1'b1, 1'b0, 1'b0);
        set_field(0);
        press(1'b0, 1'b0, 1'b1);
        check("min_dec_wrap", int'(min_o), 59);
        check("hor_no_borrow", int'(hor_o), 5);
        press(1'b0, 1'b1, 1'b0);
        check("min_inc_wrap", int'(min_o), 0);
        check("hor_no_carry", int'(hor_o), 5);

        // Simultaneous events
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        h0 = m_t / 3600;
        press(1'b0, 1'b1, 1'b1);
        check("incdec_hor", int'(hor_o), h0);
        press(1'b1, 1'b1, 1'b0);
        check("modoinc_mode", int'(modo_o), 2);
        check("modoinc_hor", int'(hor_o), h0);

        // Long hold of inc in AJ_SEG
        press(1'b1, 1'b0, 1'b0);
        set_field(0);
`ifdef AJUSTE_AUTOREPEAT_EN
        n_rep = 1 + 1 + (40 - RD) / RP;
`else
        n_rep = 1;
`endif
        for (int i = 0; i < n_rep; i++) begin
            m_t = m_t - (m_t % 60) + ((m_t % 60) + 1) % 60;
            e.mode = 3;
            e.t = m_t;
            q.push_back(e);
        end
        b_inc = 1'b1;
        k = 0;
        while (seg_o == 6'd0 && k < 40) begin
            cyc(1);
            k++;
        end
        check("hold_started", int'(seg_o != 6'd0), 1);
        cyc(36);
        b_inc = 1'b0;
        cyc(12);
        sync();
        check("hold_seg", int'(seg_o), n_rep);

        // Random button combinations against the model
        repeat (12) begin
            r = 3'($urandom_range(0, 7));
            press(r[0], r[1], r[2]);
        end
        cyc(2);
        chk_now("random_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relogio_contador_ajuste.md
# relogio_contador_ajuste

Timekeeping core of the clock: divides `clk_100MHz` down to a 1 Hz tick, keeps seconds/minutes/hours in 24 h format, and lets the user set the time with three push-buttons. It sits directly upstream of the display stage. It drives that stage's `segundos`, `minutos`, `horas` and `modo_ajuste` inputs from registered outputs.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per 1 s tick; minimum 2.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz); minimum 1.
- `REPEAT_DELAY`, 50_000_000: hold time before auto-repeat starts. Used only with the macro.
- `REPEAT_PERIOD`, 20_000_000: auto-repeat interval. Used only with the macro.

Ports:
- `clk_100MHz` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `btn_modo` in 1: raw asynchronous button; each press advances the adjust mode.
- `btn_inc` in 1: raw asynchronous button; increments the selected field.
- `btn_dec` in 1: raw asynchronous button; decrements the selected field.
- `segundos` out 6: 0–59, registered.
- `minutos` out 6: 0–59, registered.
- `horas` out 6: 0–23, registered.
- `modo_ajuste` out 2: 0 = normal, 1 = hours, 2 = minutes, 3 = seconds.
- `tick_1hz` out 1: one-cycle pulse on every prescaler terminal count, in normal mode only.

## Operation
- **Button conditioning**
  - Each button passes through a 2-FF synchronizer and then its own debounce counter.
  - The debounced level changes only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle press event. Release produces no event.
- **Mode FSM**
  - States: NORMAL(0) → AJ_HORAS(1) → AJ_MIN(2) → AJ_SEG(3) → NORMAL, advancing on each `btn_modo` event.
  - `modo_ajuste` equals the state encoding.
- **NORMAL state**
  - The prescaler counts 0..`TICK_DIV`-1. At the terminal count it wraps to 0 and asserts `tick_1hz`.
  - On a tick, `segundos` increments. 59 wraps to 0 and carries into `minutos`. `minutos` 59 wraps to 0 and carries into `horas`. `horas` 23 wraps to 0, so 23:59:59 → 00:00:00.
  - inc/dec events are ignored.
- **Adjust states**
  - The prescaler is held at 0, time is frozen, and `tick_1hz` = 0.
  - An inc event adds 1 to the selected field; a dec event subtracts 1.
  - Wrap stays within the field, with no carry: hours 23↔0, minutes/seconds 59↔0.
- **Leaving AJ_SEG**
  - On entering NORMAL, the prescaler restarts from 0. The first tick arrives `TICK_DIV` cycles after the mode event.
- **Simultaneous events**
  - inc and dec in the same cycle: no change.
  - A modo event in the same cycle as inc/dec: the mode advances and inc/dec is discarded.
- **Reset**
  - Counters, prescaler, debounce state and FSM return to reset values at the next edge, even mid-debounce or mid-adjust.
  - Reset values: outputs 0, `modo_ajuste` = 0 (NORMAL), `tick_1hz` = 0, all debounced levels 0.

## Timing
- Raw button edge to press event: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle, given a clean input.
- Press event to updated output register: 1 cycle.
- `tick_1hz` is asserted in the same cycle the prescaler is at terminal count. The time outputs show the new value on the following cycle.
- All outputs come straight from flops, with no combinational path from inputs.

## Configuration
- Macro: `AJUSTE_AUTOREPEAT_EN`.
- **Defined:**
  - In an adjust state, holding inc or dec (debounced level high) for `REPEAT_DELAY` cycles generates an extra event.
  - Further events follow every `REPEAT_PERIOD` cycles while the button stays held.
  - Releasing the button or a modo event clears the repeat counter.
  - If both inc and dec are held, no repeat occurs.
- **Undefined:** one event per press only. The repeat counters and parameters are unused and must synthesize away.

## Test plan
Bench parameters: `TICK_DIV`=10, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.

1. **Reset, then run.**
   - Reset, then run 600 cycles.
   - Required: `segundos`=60 mod 60 → 0, `minutos`=1, `horas`=0; exactly 60 `tick_1hz` pulses.
2. **Midnight rollover.**
   - Preset via adjust to 23:59:59, return to NORMAL, wait 10 cycles.
   - Required: output 00:00:00 and `modo_ajuste`=0.
3. **Debounce rejection.**
   - Toggle `btn_modo` 1/0 every 2 cycles for 40 cycles, then hold high for 10 cycles.
   - Required: exactly one mode advance, to `modo_ajuste`=1.
4. **Field adjust without carry.**
   - In AJ_MIN with `minutos`=0 and `horas`=5, press dec once.
   - Required: `minutos`=59, `horas`=5. Then press inc → `minutos`=0.
5. **Simultaneous events.**
   - Press inc and dec in the same cycle in AJ_HORAS: `horas` unchanged.
   - Press modo+inc in the same cycle: mode goes to AJ_MIN, `horas` unchanged.
6. **Auto-repeat (`AJUSTE_AUTOREPEAT_EN` defined).**
   - Hold `btn_inc` in AJ_SEG from `segundos`=0 for 40 cycles after debounce.
   - Required: `segundos`=1+1+4=6 (press, first repeat at 20, repeats at 25/30/35/40 → total 6).
   - Without the macro: `segundos`=1.
